// File: rtl/bsg_cgol_job_arb_if.sv
// Requester/engine handshake bundle for the cgol job arbiter.
// master drives the requester and engine inputs; slave is the arbiter.
interface bsg_cgol_job_arb_if #(
    parameter int unsigned num_req_p         = 4,
    parameter int unsigned max_game_length_p = 1024
);
    localparam int unsigned W = ($clog2(max_game_length_p + 1) > 1) ? $clog2(max_game_length_p + 1) : 1;

    logic [num_req_p-1:0]   req_v_i;
    logic [num_req_p*W-1:0] req_frames_i;
    logic [num_req_p-1:0]   req_ready_o;
    logic [num_req_p-1:0]   res_v_o;
    logic [num_req_p-1:0]   res_yumi_i;
    logic                   eng_v_o;
    logic [W-1:0]           eng_frames_o;
    logic                   eng_ready_i;
    logic                   eng_v_i;
    logic                   eng_yumi_o;

    modport master (
        output req_v_i, req_frames_i, res_yumi_i, eng_ready_i, eng_v_i,
        input  req_ready_o, res_v_o, eng_v_o, eng_frames_o, eng_yumi_o
    );

    modport slave (
        input  req_v_i, req_frames_i, res_yumi_i, eng_ready_i, eng_v_i,
        output req_ready_o, res_v_o, eng_v_o, eng_frames_o, eng_yumi_o
    );
endinterface

// File: rtl/bsg_cgol_job_arb.sv
// Round-robin arbiter sharing one cgol engine among num_req_p job requesters.
// Zero-frame jobs bypass the engine and return a result directly.
module bsg_cgol_job_arb #(
    parameter int unsigned num_req_p         = 4,
    parameter int unsigned max_game_length_p = 1024
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bsg_cgol_job_arb_if.slave      bus,
    output logic [((num_req_p > 1) ? $clog2(num_req_p) : 1)-1:0] owner_o,
    output logic                   busy_o,
    output logic [15:0]            done_count_o
);
    localparam int unsigned W = ($clog2(max_game_length_p + 1) > 1) ? $clog2(max_game_length_p + 1) : 1;
    localparam int unsigned I = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_BUSY   = 2'd2;
    localparam logic [1:0] ST_RETURN = 2'd3;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [I-1:0] r_owner;
    logic [I-1:0] r_rr_ptr;
    logic [W-1:0] r_frames;
    logic         r_used;
    logic [15:0]  r_done_count;

    logic         w_gnt_found;
    logic [I-1:0] w_gnt_idx;
    logic [I:0]   w_sum;
    logic [I-1:0] w_idx;
    logic [W-1:0] w_frames_sel;
    logic [W-1:0] w_frames_clamp;
    logic         w_hs;
    logic         w_ret_done;
    logic [I-1:0] w_rr_nxt;

    // First valid requester at or after rr_ptr, wrapping; lowest offset wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr_ptr} + (I+1)'(i);
            if (w_sum >= (I+1)'(num_req_p))
                w_idx = I'(w_sum - (I+1)'(num_req_p));
            else
                w_idx = I'(w_sum);
            if (bus.req_v_i[w_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_idx;
            end
        end
    end

    assign w_frames_sel   = bus.req_frames_i[w_gnt_idx*W +: W];
    assign w_frames_clamp = (w_frames_sel > W'(max_game_length_p)) ? W'(max_game_length_p) : w_frames_sel;
    assign w_hs           = (r_state == ST_IDLE) && w_gnt_found;
    assign w_ret_done     = (r_state == ST_RETURN) && bus.res_yumi_i[r_owner];
    assign w_rr_nxt       = (r_owner == I'(num_req_p - 1)) ? '0 : r_owner + I'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt     = r_state;
        bus.req_ready_o = '0;
        bus.res_v_o     = '0;
        bus.eng_v_o     = 1'b0;
        bus.eng_yumi_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_found) begin
                    bus.req_ready_o = num_req_p'(1) << w_gnt_idx;
                    w_state_nxt     = (w_frames_clamp != '0) ? ST_ISSUE : ST_RETURN;
                end
            end
            ST_ISSUE: begin
                bus.eng_v_o = 1'b1;
                if (bus.eng_ready_i) w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.eng_v_i) w_state_nxt = ST_RETURN;
            end
            ST_RETURN: begin
                bus.res_v_o = num_req_p'(1) << r_owner;
                if (w_ret_done) begin
                    bus.eng_yumi_o = r_used;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Job context and completion bookkeeping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_frames     <= '0;
            r_used       <= 1'b0;
            r_done_count <= '0;
        end else begin
            if (w_hs) begin
                r_owner  <= w_gnt_idx;
                r_frames <= w_frames_clamp;
                r_used   <= (w_frames_clamp != '0);
            end
            if (w_ret_done) begin
                r_rr_ptr     <= w_rr_nxt;
                r_done_count <= r_done_count + 16'd1;
            end
        end
    end

    assign bus.eng_frames_o = r_frames;
    assign owner_o          = r_owner;
    assign busy_o           = (r_state != ST_IDLE);
    assign done_count_o     = r_done_count;
endmodule

// File: tb/tb_bsg_cgol_job_arb.sv
// Directed bench for bsg_cgol_job_arb: default instance plus a max_game_length_p=1000 instance for clamping.
module tb_bsg_cgol_job_arb;
    localparam int unsigned W  = 11;
    localparam int unsigned WB = 10;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    bsg_cgol_job_arb_if #(.num_req_p(4), .max_game_length_p(1024)) ifa ();
    bsg_cgol_job_arb_if #(.num_req_p(4), .max_game_length_p(1000)) ifb ();

    logic [1:0]  owner_a, owner_b;
    logic        busy_a, busy_b;
    logic [15:0] done_a, done_b;

    bsg_cgol_job_arb #(.num_req_p(4), .max_game_length_p(1024)) dut_a (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .bus          (ifa.slave),
        .owner_o      (owner_a),
        .busy_o       (busy_a),
        .done_count_o (done_a)
    );

    bsg_cgol_job_arb #(.num_req_p(4), .max_game_length_p(1000)) dut_b (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .bus          (ifb.slave),
        .owner_o      (owner_b),
        .busy_o       (busy_b),
        .done_count_o (done_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_fr(input int k, input int v);
        ifa.req_frames_i[k*W +: W] = W'(v);
    endtask

    // Full engine job for requester g; v_after is the req_v pattern applied after the accept edge.
    task automatic job(input int g, input int fr, input logic [3:0] v_after);
        check("grant", 32'(ifa.req_ready_o), 32'(1) << g);
        cyc();
        ifa.req_v_i = v_after;
        #1;
        check("owner", 32'(owner_a), 32'(g));
        check("eng_v_issue", 32'(ifa.eng_v_o), 32'd1);
        check("eng_frames", 32'(ifa.eng_frames_o), 32'(fr));
        check("ready_nonidle", 32'(ifa.req_ready_o), 32'd0);
        cyc();
        check("eng_v_busy", 32'(ifa.eng_v_o), 32'd0);
        ifa.eng_v_i = 1'b1;
        cyc();
        check("res_v", 32'(ifa.res_v_o), 32'(1) << g);
        check("eng_yumi_wait", 32'(ifa.eng_yumi_o), 32'd0);
        ifa.res_yumi_i = 4'(32'(1) << g);
        #1;
        check("eng_yumi", 32'(ifa.eng_yumi_o), 32'd1);
        cyc();
        ifa.res_yumi_i = '0;
        ifa.eng_v_i    = 1'b0;
        #1;
    endtask

    initial begin
        reset_i          = 1'b1;
        ifa.req_v_i      = '0;
        ifa.req_frames_i = '0;
        ifa.res_yumi_i   = '0;
        ifa.eng_ready_i  = 1'b0;
        ifa.eng_v_i      = 1'b0;
        ifb.req_v_i      = '0;
        ifb.req_frames_i = '0;
        ifb.res_yumi_i   = '0;
        ifb.eng_ready_i  = 1'b0;
        ifb.eng_v_i      = 1'b0;
        #2;
        check("rst_eng_v", 32'(ifa.eng_v_o), 32'd0);
        check("rst_res_v", 32'(ifa.res_v_o), 32'd0);
        check("rst_eng_yumi", 32'(ifa.eng_yumi_o), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_owner", 32'(owner_a), 32'd0);
        check("rst_frames", 32'(ifa.eng_frames_o), 32'd0);
        check("rst_ready", 32'(ifa.req_ready_o), 32'd0);
        cyc();
        cyc();
        reset_i = 1'b0;

        // Clamp on the 1000-frame instance
        ifb.req_v_i             = 4'b0001;
        ifb.req_frames_i[0+:WB] = 10'd1023;
        #1;
        check("b_grant", 32'(ifb.req_ready_o), 32'd1);
        cyc();
        ifb.req_v_i = '0;
        #1;
        check("b_eng_v", 32'(ifb.eng_v_o), 32'd1);
        check("b_clamp", 32'(ifb.eng_frames_o), 32'd1000);
        check("b_owner", 32'(owner_b), 32'd0);

        // Single job on requester 0
        ifa.eng_ready_i = 1'b1;
        ifa.req_v_i     = 4'b0001;
        set_fr(0, 5);
        #1;
        job(0, 5, 4'b0000);
        check("single_done", 32'(done_a), 32'd1);
        check("single_idle", 32'(busy_a), 32'd0);

        reset_i = 1'b1;
        #1;
        check("rst2_done", 32'(done_a), 32'd0);
        cyc();
        reset_i = 1'b0;

        // Round-robin with all requesters valid
        for (int k = 0; k < 4; k++) set_fr(k, k + 3);
        ifa.req_v_i = 4'b1111;
        #1;
        for (int j = 0; j < 5; j++) job(j % 4, (j % 4) + 3, (j == 4) ? 4'b0000 : 4'b1111);
        check("rr_done", 32'(done_a), 32'd5);

        // Zero-frame bypass on requester 2 (rr_ptr is 1)
        ifa.req_v_i = 4'b0100;
        set_fr(2, 0);
        #1;
        check("zf_grant", 32'(ifa.req_ready_o), 32'b0100);
        cyc();
        ifa.req_v_i = '0;
        #1;
        check("zf_res_v", 32'(ifa.res_v_o), 32'b0100);
        check("zf_eng_v", 32'(ifa.eng_v_o), 32'd0);
        check("zf_busy", 32'(busy_a), 32'd1);
        check("zf_owner", 32'(owner_a), 32'd2);
        ifa.res_yumi_i = 4'b0100;
        #1;
        check("zf_eng_yumi", 32'(ifa.eng_yumi_o), 32'd0);
        cyc();
        ifa.res_yumi_i = '0;
        #1;
        check("zf_done", 32'(done_a), 32'd6);
        check("zf_idle", 32'(busy_a), 32'd0);

        // Engine backpressure on requester 0 (rr_ptr is 3, wraps to 0)
        ifa.eng_ready_i = 1'b0;
        ifa.req_v_i     = 4'b0001;
        set_fr(0, 7);
        #1;
        check("bp_grant", 32'(ifa.req_ready_o), 32'b0001);
        cyc();
        ifa.req_v_i = 4'b1111;
        ifa.eng_v_i = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            check("bp_eng_v", 32'(ifa.eng_v_o), 32'd1);
            check("bp_frames", 32'(ifa.eng_frames_o), 32'd7);
            check("bp_ready", 32'(ifa.req_ready_o), 32'd0);
            cyc();
        end
        check("bp_still_issue", 32'(ifa.eng_v_o), 32'd1);
        ifa.eng_v_i     = 1'b0;
        ifa.req_v_i     = '0;
        ifa.eng_ready_i = 1'b1;
        cyc();
        check("bp_busy_eng_v", 32'(ifa.eng_v_o), 32'd0);
        ifa.eng_v_i = 1'b1;
        cyc();
        ifa.res_yumi_i = 4'b0010;
        #1;
        check("bp_nonowner_yumi", 32'(ifa.eng_yumi_o), 32'd0);
        cyc();
        check("bp_nonowner_res_v", 32'(ifa.res_v_o), 32'b0001);
        check("bp_nonowner_done", 32'(done_a), 32'd6);
        ifa.res_yumi_i = 4'b0001;
        #1;
        check("bp_eng_yumi", 32'(ifa.eng_yumi_o), 32'd1);
        cyc();
        ifa.res_yumi_i = '0;
        ifa.eng_v_i    = 1'b0;
        #1;
        check("bp_done", 32'(done_a), 32'd7);

        // Forfeit: request withdrawn before the edge
        ifa.req_v_i = 4'b0010;
        #1;
        check("ff_grant", 32'(ifa.req_ready_o), 32'b0010);
        ifa.req_v_i = '0;
        cyc();
        check("ff_idle", 32'(busy_a), 32'd0);
        check("ff_owner_held", 32'(owner_a), 32'd0);

        // Reset while BUSY
        ifa.req_v_i = 4'b0100;
        set_fr(2, 9);
        #1;
        cyc();
        ifa.req_v_i = '0;
        cyc();
        check("mr_busy", 32'(busy_a), 32'd1);
        check("mr_owner", 32'(owner_a), 32'd2);
        #2;
        reset_i = 1'b1;
        #1;
        check("mr_busy_rst", 32'(busy_a), 32'd0);
        check("mr_eng_v", 32'(ifa.eng_v_o), 32'd0);
        check("mr_res_v", 32'(ifa.res_v_o), 32'd0);
        check("mr_eng_yumi", 32'(ifa.eng_yumi_o), 32'd0);
        check("mr_done", 32'(done_a), 32'd0);
        check("mr_owner_rst", 32'(owner_a), 32'd0);
        check("mr_frames", 32'(ifa.eng_frames_o), 32'd0);
        check("mr_b_eng_v", 32'(ifb.eng_v_o), 32'd0);
        check("mr_b_done", 32'(done_b), 32'd0);
        cyc();
        reset_i     = 1'b0;
        ifa.req_v_i = 4'b1111;
        #1;
        check("mr_first_grant", 32'(ifa.req_ready_o), 32'b0001);
        cyc();
        check("mr_first_owner", 32'(owner_a), 32'd0);
        check("mr_b_busy", 32'(busy_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
